// File: rtl/multicycle_controller.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshake,
// optional wait timeout trap and sticky illegal-opcode flag.
module multicycle_controller #(
  parameter int OPCODE_W   = 6,
  parameter int ALU_CTRL_W = 4,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  iord,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  reg_dst,
  output logic                  reg_write,
  output logic                  alu_src,
  output logic                  shamt_sel,
  output logic                  mem_to_reg,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal_op,
  output logic                  timeout,
  output logic [2:0]            state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(6'b000001);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_INC  = OPCODE_W'(6'b000011);
  localparam logic [OPCODE_W-1:0] OP_DEC  = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(6'b000101);
  localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(6'b000110);
  localparam logic [OPCODE_W-1:0] OP_XOR  = OPCODE_W'(6'b000111);
  localparam logic [OPCODE_W-1:0] OP_NOT  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_SHL  = OPCODE_W'(6'b001001);
  localparam logic [OPCODE_W-1:0] OP_SHR  = OPCODE_W'(6'b001010);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001011);
  localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(6'b001100);
  localparam logic [OPCODE_W-1:0] OP_CMP  = OPCODE_W'(6'b001101);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100010);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b100100);

  // Returns {alu_src, shamt_sel, alu_control[3:0]}
  function automatic logic [5:0] decode(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_ADD:  decode = 6'b00_0101;
      OP_ADDI: decode = 6'b10_0101;
      OP_SUB:  decode = 6'b00_0110;
      OP_SUBI: decode = 6'b10_0110;
      OP_INC:  decode = 6'b00_0111;
      OP_DEC:  decode = 6'b00_0100;
      OP_AND:  decode = 6'b00_0001;
      OP_OR:   decode = 6'b00_0011;
      OP_XOR:  decode = 6'b00_0010;
      OP_NOT:  decode = 6'b00_0000;
      OP_SHL:  decode = 6'b01_1001;
      OP_SHR:  decode = 6'b01_1010;
      OP_CMP:  decode = 6'b00_1000;
      OP_LW:   decode = 6'b10_0101;
      OP_SW:   decode = 6'b10_0101;
      default: decode = 6'b00_0000;
    endcase
  endfunction

  function automatic logic known(input logic [OPCODE_W-1:0] op);
    known = op inside {OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_INC, OP_DEC, OP_AND, OP_OR,
                       OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_CMP, OP_LW, OP_SW};
  endfunction

  logic [2:0]          state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                illegal_q, illegal_d, timeout_q, timeout_d;
  logic [5:0]          dec_op;
  logic                is_lw, is_sw, waiting, wait_hit, dp_active;
  logic [2:0]          next_fetch;

  assign dec_op     = decode(op_q);
  assign is_lw      = (op_q == OP_LW);
  assign is_sw      = (op_q == OP_SW);
  assign waiting    = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign wait_hit   = (TIMEOUT != 0) && waiting && (cnt_inc >= CNT_W'(TIMEOUT));
  assign next_fetch = run ? S_FETCH : S_IDLE;
  assign dp_active  = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else if (wait_hit) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end
      end
      S_DECODE: begin
        op_d = opcode;
        if (known(opcode)) state_d = S_EXEC;
        else begin
          illegal_d = 1'b1;
          state_d   = next_fetch;
        end
      end
      S_EXEC:   state_d = (is_lw || is_sw) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ready) state_d = is_sw ? next_fetch : S_WB;
        else if (wait_hit) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end
      end
      S_WB:     state_d = next_fetch;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
    // Any state change restarts the wait count, so each FETCH/MEM entry begins at zero.
    if (state_d != state_q) cnt_d = '0;
    else if (waiting)       cnt_d = cnt_inc;
    else                    cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_dst     = 1'b0;
    reg_write   = 1'b0;
    alu_src     = 1'b0;
    shamt_sel   = 1'b0;
    mem_to_reg  = 1'b0;
    alu_control = '0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_MEM: begin
        iord      = 1'b1;
        mem_read  = is_lw;
        mem_write = is_sw;
      end
      S_WB:    reg_write = 1'b1;
      default: ;
    endcase
    if (dp_active) begin
      reg_dst     = !is_lw;
      mem_to_reg  = !is_lw;
      alu_src     = dec_op[5];
      shamt_sel   = dec_op[4];
      alu_control = ALU_CTRL_W'(dec_op[3:0]);
    end
    if (state_q == S_MEM) alu_control = ALU_CTRL_W'(4'b0101);
  end

  assign illegal_op = illegal_q;
  assign timeout    = timeout_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle stimulus and expected outputs are
// queued together, then drained one clock at a time and compared.
module tb_multicycle_controller;

  localparam logic [5:0] ADD  = 6'b000001;
  localparam logic [5:0] SUBI = 6'b001100;
  localparam logic [5:0] SHL  = 6'b001001;
  localparam logic [5:0] LW   = 6'b100010;
  localparam logic [5:0] SW   = 6'b100100;
  localparam logic [5:0] BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, iord, mem_read, mem_write, reg_dst, reg_write;
  logic       alu_src, shamt_sel, mem_to_reg, illegal_op, timeout;
  logic [3:0] alu_control;
  logic [2:0] state;

  multicycle_controller #(.OPCODE_W(6), .ALU_CTRL_W(4), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .reg_dst(reg_dst), .reg_write(reg_write), .alu_src(alu_src),
    .shamt_sel(shamt_sel), .mem_to_reg(mem_to_reg), .alu_control(alu_control),
    .illegal_op(illegal_op), .timeout(timeout), .state(state)
  );

  always #5 clk = ~clk;

  // {state, pc_write, ir_write, iord, mem_read, mem_write, reg_dst, reg_write, alu_src,
  //  shamt_sel, mem_to_reg, alu_control, illegal_op, timeout}
  logic [18:0] obs;
  assign obs = {state, pc_write, ir_write, iord, mem_read, mem_write, reg_dst, reg_write,
                alu_src, shamt_sel, mem_to_reg, alu_control, illegal_op, timeout};

  typedef struct packed {
    logic        run;
    logic [5:0]  opc;
    logic        rdy;
    logic [18:0] exp;
  } ent_t;

  ent_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input logic r, input logic [5:0] o, input logic rd, input logic [2:0] st,
                      input logic [9:0] str, input logic [3:0] alu, input logic [1:0] fl);
    sb.push_back({r, o, rd, st, str, alu, fl});
  endtask

  task automatic test_reset();
    run = 1'b1; mem_ready = 1'b1; opcode = ADD;
    @(posedge clk); #1;
    n_cmp++;
    if (obs !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_hold: got %b want %b", obs, 19'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (obs !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_idle: got %b want %b", obs, 19'd0);
    end
  endtask

  task automatic test_add();
    ent_t e;
    int   k = 0;
    push(1, ADD, 1, 3'd0, 10'b0000000000, 4'b0000, 2'b00);
    push(1, ADD, 1, 3'd1, 10'b1101000000, 4'b0000, 2'b00);
    push(1, ADD, 1, 3'd2, 10'b0000000000, 4'b0000, 2'b00);
    push(1, ADD, 1, 3'd3, 10'b0000010001, 4'b0101, 2'b00);
    push(1, ADD, 1, 3'd5, 10'b0000011001, 4'b0101, 2'b00);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      run = e.run; opcode = e.opc; mem_ready = e.rdy;
      #3;
      n_cmp++;
      if (obs !== e.exp) begin
        n_bad++;
        $display("FAIL add cyc%0d: got %b want %b", k, obs, e.exp);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    ent_t e;
    int   k = 0;
    // Arrives from test_add already in FETCH; run drops but SUBI still completes.
    push(0, SUBI, 1, 3'd1, 10'b1101000000, 4'b0000, 2'b00);
    push(0, SUBI, 1, 3'd2, 10'b0000000000, 4'b0000, 2'b00);
    push(0, SUBI, 1, 3'd3, 10'b0000010101, 4'b0110, 2'b00);
    push(0, SUBI, 1, 3'd5, 10'b0000011101, 4'b0110, 2'b00);
    push(0, SUBI, 1, 3'd0, 10'b0000000000, 4'b0000, 2'b00);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      run = e.run; opcode = e.opc; mem_ready = e.rdy;
      #3;
      n_cmp++;
      if (obs !== e.exp) begin
        n_bad++;
        $display("FAIL b2b cyc%0d: got %b want %b", k, obs, e.exp);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    ent_t e;
    int   k = 0;
    push(1, LW, 1, 3'd0, 10'b0000000000, 4'b0000, 2'b00);
    push(1, LW, 1, 3'd1, 10'b1101000000, 4'b0000, 2'b00);
    push(1, LW, 0, 3'd2, 10'b0000000000, 4'b0000, 2'b00);
    push(0, LW, 0, 3'd3, 10'b0000000100, 4'b0101, 2'b00);
    for (int i = 0; i < 3; i++) push(0, LW, 0, 3'd4, 10'b0011000100, 4'b0101, 2'b00);
    push(0, LW, 1, 3'd4, 10'b0011000100, 4'b0101, 2'b00);
    push(0, LW, 1, 3'd5, 10'b0000001100, 4'b0101, 2'b00);
    push(0, LW, 0, 3'd0, 10'b0000000000, 4'b0000, 2'b00);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      run = e.run; opcode = e.opc; mem_ready = e.rdy;
      #3;
      n_cmp++;
      if (obs !== e.exp) begin
        n_bad++;
        $display("FAIL lw cyc%0d: got %b want %b", k, obs, e.exp);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    ent_t e;
    int   k = 0;
    push(1, SW, 1, 3'd0, 10'b0000000000, 4'b0000, 2'b00);
    push(1, SW, 1, 3'd1, 10'b1101000000, 4'b0000, 2'b00);
    push(1, SW, 1, 3'd2, 10'b0000000000, 4'b0000, 2'b00);
    push(0, SW, 1, 3'd3, 10'b0000010101, 4'b0101, 2'b00);
    push(0, SW, 0, 3'd4, 10'b0010110101, 4'b0101, 2'b00);
    push(0, SW, 1, 3'd4, 10'b0010110101, 4'b0101, 2'b00);
    push(0, SW, 0, 3'd0, 10'b0000000000, 4'b0000, 2'b00);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      run = e.run; opcode = e.opc; mem_ready = e.rdy;
      #3;
      n_cmp++;
      if (obs !== e.exp) begin
        n_bad++;
        $display("FAIL sw cyc%0d: got %b want %b", k, obs, e.exp);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_run_drop_shift();
    ent_t e;
    int   k = 0;
    push(1, SHL, 1, 3'd0, 10'b0000000000, 4'b0000, 2'b00);
    push(1, SHL, 1, 3'd1, 10'b1101000000, 4'b0000, 2'b00);
    push(1, SHL, 1, 3'd2, 10'b0000000000, 4'b0000, 2'b00);
    push(0, SHL, 1, 3'd3, 10'b0000010011, 4'b1001, 2'b00);
    push(0, SHL, 1, 3'd5, 10'b0000011011, 4'b1001, 2'b00);
    push(0, SHL, 1, 3'd0, 10'b0000000000, 4'b0000, 2'b00);
    push(0, SHL, 1, 3'd0, 10'b0000000000, 4'b0000, 2'b00);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      run = e.run; opcode = e.opc; mem_ready = e.rdy;
      #3;
      n_cmp++;
      if (obs !== e.exp) begin
        n_bad++;
        $display("FAIL shl cyc%0d: got %b want %b", k, obs, e.exp);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    ent_t e;
    int   k = 0;
    push(1, BAD, 1, 3'd0, 10'b0000000000, 4'b0000, 2'b00);
    push(1, BAD, 1, 3'd1, 10'b1101000000, 4'b0000, 2'b00);
    push(1, BAD, 1, 3'd2, 10'b0000000000, 4'b0000, 2'b00);
    push(0, BAD, 1, 3'd1, 10'b1101000000, 4'b0000, 2'b10);
    push(0, BAD, 1, 3'd2, 10'b0000000000, 4'b0000, 2'b10);
    push(0, BAD, 1, 3'd0, 10'b0000000000, 4'b0000, 2'b10);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      run = e.run; opcode = e.opc; mem_ready = e.rdy;
      #3;
      n_cmp++;
      if (obs !== e.exp) begin
        n_bad++;
        $display("FAIL illegal cyc%0d: got %b want %b", k, obs, e.exp);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    ent_t e;
    int   k = 0;
    push(1, ADD, 0, 3'd0, 10'b0000000000, 4'b0000, 2'b10);
    for (int i = 0; i < 4; i++) push(1, ADD, 0, 3'd1, 10'b0001000000, 4'b0000, 2'b10);
    push(1, ADD, 1, 3'd6, 10'b0000000000, 4'b0000, 2'b11);
    push(1, ADD, 1, 3'd6, 10'b0000000000, 4'b0000, 2'b11);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      run = e.run; opcode = e.opc; mem_ready = e.rdy;
      #3;
      n_cmp++;
      if (obs !== e.exp) begin
        n_bad++;
        $display("FAIL timeout cyc%0d: got %b want %b", k, obs, e.exp);
      end
      k++;
      @(posedge clk); #1;
    end
    // Asynchronous reset between clock edges while trapped.
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 19'd0) begin
      n_bad++;
      $display("FAIL async_reset: got %b want %b", obs, 19'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (obs !== 19'd0) begin
      n_bad++;
      $display("FAIL post_reset_idle: got %b want %b", obs, 19'd0);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_lw();
    test_sw();
    test_run_drop_shift();
    test_illegal();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
